// File: rtl/aes_shiftrows_pipe.sv
// aes_shiftrows_pipe: pipelined ShiftRows/InvShiftRows with valid/ready, tag and flush; AES_SHIFTROWS_BEATCNT_EN adds beat_cnt
module aes_shiftrows_pipe #(
  parameter int LANES  = 1,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [128*LANES-1:0]   in_data,
  input  logic [LANES-1:0]       in_inv,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [128*LANES-1:0]   out_data,
  output logic [TAG_W-1:0]       out_tag
`ifdef AES_SHIFTROWS_BEATCNT_EN
  ,
  output logic [31:0]            beat_cnt
`endif
);
  localparam int DW = 128*LANES;
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("aes_shiftrows_pipe: STAGES must be in 1..4");
  end
  logic [DW-1:0]    perm;
  logic [DW-1:0]    d_q [STAGES];
  logic [TAG_W-1:0] t_q [STAGES];
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] pv;
  logic [DW-1:0]    pd [STAGES];
  logic [TAG_W-1:0] pt [STAGES];
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    for (genvar k = 0; k < 16; k++) begin : g_byte
      localparam int R  = k % 4;
      localparam int C  = k / 4;
      localparam int FS = 4*((C+R)%4) + R;
      localparam int IS = 4*((C+4-R)%4) + R;
      assign perm[128*l+127-8*k -: 8] = in_inv[l] ? in_data[128*l+127-8*IS -: 8]
                                                  : in_data[128*l+127-8*FS -: 8];
    end
  end
  // a stage loads unless it and every stage after it are full while the output stalls
  for (genvar i = 0; i < STAGES; i++) begin : g_ld
    assign ld[i] = out_ready || !(&v_q[STAGES-1:i]);
  end
  assign in_ready = ld[0] && !flush;
  always_comb begin
    pv[0] = in_valid && in_ready;
    pd[0] = perm;
    pt[0] = in_tag;
    for (int i = 1; i < STAGES; i++) begin
      pv[i] = v_q[i-1];
      pd[i] = d_q[i-1];
      pt[i] = t_q[i-1];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        d_q[i] <= '0;
        t_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (flush) v_q[i] <= 1'b0;
        else if (ld[i]) v_q[i] <= pv[i];
        if (ld[i] && pv[i]) begin
          d_q[i] <= pd[i];
          t_q[i] <= pt[i];
        end
      end
    end
  end
  assign out_valid = v_q[STAGES-1];
  assign out_data  = d_q[STAGES-1];
  assign out_tag   = t_q[STAGES-1];
`ifdef AES_SHIFTROWS_BEATCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat_cnt <= '0;
    else if (flush) beat_cnt <= '0;
    else if (out_valid && out_ready) beat_cnt <= beat_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_aes_shiftrows_pipe.sv
// tb_aes_shiftrows_pipe: randomized scoreboard bench for aes_shiftrows_pipe (LANES=2, STAGES=3)
module tb_aes_shiftrows_pipe;
  localparam int LANES  = 2;
  localparam int STAGES = 3;
  localparam int TAG_W  = 4;
  localparam int DW     = 128*LANES;
  localparam logic [127:0] V = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] F = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [127:0] I = 128'h000d0a0704010e0b0805020f0c090603;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [DW-1:0] in_data = '0, out_data;
  logic [LANES-1:0] in_inv = '0;
  logic [TAG_W-1:0] in_tag = '0, out_tag;
`ifdef AES_SHIFTROWS_BEATCNT_EN
  logic [31:0] beat_cnt;
`endif
  int tests = 0, fails = 0, out_cnt = 0;
  logic [DW+TAG_W-1:0] sb[$];
  logic [DW-1:0] prev_d;
  logic [TAG_W-1:0] prev_t;
  bit prev_stall = 0;
  always #5 clk = ~clk;
  aes_shiftrows_pipe #(.LANES(LANES), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
`ifdef AES_SHIFTROWS_BEATCNT_EN
    , .beat_cnt(beat_cnt)
`endif
  );
  function automatic logic [127:0] ref_sr(input logic [127:0] s, input logic inv);
    logic [7:0] m [4][4];
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) m[r][c] = s[127-8*(4*c+r) -: 8];
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = m[r][inv ? (c+4-r)%4 : (c+r)%4];
    return o;
  endfunction
  function automatic logic [DW-1:0] ref_beat(input logic [DW-1:0] d, input logic [LANES-1:0] inv);
    logic [DW-1:0] o;
    for (int l = 0; l < LANES; l++) o[128*l +: 128] = ref_sr(d[128*l +: 128], inv[l]);
    return o;
  endfunction
  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] o;
    for (int w = 0; w < DW/32; w++) o[32*w +: 32] = $urandom();
    return o;
  endfunction
  // one clock cycle: called at a negedge with inputs already driven
  task automatic step();
    logic [DW+TAG_W-1:0] e;
    logic exp_rdy;
    #1;
    exp_rdy = !flush && !(sb.size() == STAGES && !out_ready);
    tests++;
    if (in_ready !== exp_rdy) begin
      fails++;
      $display("FAIL in_ready: got %b want %b (occupancy %0d)", in_ready, exp_rdy, sb.size());
    end
    if (prev_stall) begin
      tests++;
      if (out_valid !== 1'b1 || out_data !== prev_d || out_tag !== prev_t) begin
        fails++;
        $display("FAIL stall_stable: valid %b tag %h data %h, want held tag %h data %h", out_valid, out_tag, out_data, prev_t, prev_d);
      end
    end
    if (out_valid && out_ready) begin
      tests++;
      out_cnt++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_beat: tag %h data %h, want none", out_tag, out_data);
      end else begin
        e = sb.pop_front();
        if ({out_data, out_tag} !== e) begin
          fails++;
          $display("FAIL beat: got tag %h data %h, want tag %h data %h", out_tag, out_data, e[TAG_W-1:0], e[DW+TAG_W-1:TAG_W]);
        end
      end
    end
    if (in_valid && in_ready) sb.push_back({ref_beat(in_data, in_inv), in_tag});
    prev_stall = out_valid && !out_ready && !flush;
    prev_d = out_data;
    prev_t = out_tag;
    if (flush) sb.delete();
    @(negedge clk);
  endtask
  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 20 && sb.size() != 0; n++) step();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d beats lost, want 0", sb.size());
    end
  endtask
  task automatic test_reset();
    #1;
    tests += 3;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    if (out_data !== '0) begin fails++; $display("FAIL reset_data: got %h want 0", out_data); end
    if (out_tag !== '0) begin fails++; $display("FAIL reset_tag: got %h want 0", out_tag); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    @(negedge clk);
  endtask
  task automatic run_vector(input logic [DW-1:0] d, input logic [LANES-1:0] inv, input logic [DW-1:0] exp, input string nm);
    int lat;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = d;
    in_inv = inv;
    in_tag = 4'h5;
    step();
    in_valid = 1'b0;
    for (lat = 1; lat < 10; lat++) begin
      #1;
      if (out_valid) break;
      @(negedge clk);
    end
    tests += 2;
    if (lat !== STAGES) begin fails++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, STAGES); end
    if (out_data !== exp || out_tag !== 4'h5) begin
      fails++;
      $display("FAIL %s_data: got %h tag %h want %h tag 5", nm, out_data, out_tag, exp);
    end
    step();
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL %s_single: out_valid got %b want 0", nm, out_valid); end
    @(negedge clk);
  endtask
  task automatic test_vectors();
    run_vector({V, V}, 2'b10, {I, F}, "fwd_inv");
    run_vector({F, I}, 2'b10, {V, V}, "roundtrip");
    run_vector({V, V}, 2'b00, {F, F}, "fwd_only");
  endtask
  task automatic test_backpressure();
    int sent = 0;
    int c;
    logic acc;
    out_cnt = 0;
    for (c = 0; c < 60 && out_cnt < 8; c++) begin
      out_ready = !(c >= 2 && c <= 9);
      in_valid = sent < 8;
      in_tag = TAG_W'(sent + 1);
      in_data = rnd_data();
      in_inv = LANES'($urandom());
      #1;
      acc = in_valid && in_ready;
      if (c == 9) begin
        tests++;
        if (sent !== STAGES || in_ready !== 1'b0) begin
          fails++;
          $display("FAIL bp_fill: accepted %0d ready %b, want %0d and 0", sent, in_ready, STAGES);
        end
      end
      step();
      if (acc) sent++;
    end
    tests++;
    if (out_cnt !== 8 || sb.size() != 0) begin
      fails++;
      $display("FAIL bp_drain: got %0d outputs (%0d pending), want 8 (0)", out_cnt, sb.size());
    end
  endtask
  task automatic fill(input int n);
    out_ready = 1'b0;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data = rnd_data();
      in_inv = LANES'($urandom());
      in_tag = TAG_W'($urandom());
      step();
    end
  endtask
  task automatic test_flush();
    fill(STAGES);
    flush = 1'b1;
    in_valid = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 2*STAGES; k++) begin
      #1;
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: cycle %0d got %b want 0", k, out_valid); end
      @(negedge clk);
    end
  endtask
  task automatic test_async_reset();
    fill(STAGES);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests += 2;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL areset_valid: got %b want 0", out_valid); end
    if (out_data !== '0 || out_tag !== '0) begin fails++; $display("FAIL areset_data: got %h tag %h want 0", out_data, out_tag); end
    sb.delete();
    prev_stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL areset_ready: got %b want 1", in_ready); end
    @(negedge clk);
  endtask
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(0, 39) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = !flush && ($urandom_range(0, 2) != 0);
      in_data = rnd_data();
      in_inv = LANES'($urandom());
      in_tag = TAG_W'($urandom());
      step();
    end
    flush = 1'b0;
    drain();
  endtask
`ifdef AES_SHIFTROWS_BEATCNT_EN
  task automatic send(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      out_ready = 1'b1;
      in_data = rnd_data();
      in_tag = TAG_W'(k);
      step();
    end
    drain();
  endtask
  task automatic test_counter();
    out_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    tests++;
    if (beat_cnt !== 32'd0) begin fails++; $display("FAIL cnt_clear0: got %0d want 0", beat_cnt); end
    @(negedge clk);
    send(5);
    #1;
    tests++;
    if (beat_cnt !== 32'd5) begin fails++; $display("FAIL cnt_5: got %0d want 5", beat_cnt); end
    @(negedge clk);
    flush = 1'b1;
    out_ready = 1'b0;
    step();
    flush = 1'b0;
    #1;
    tests++;
    if (beat_cnt !== 32'd0) begin fails++; $display("FAIL cnt_flush: got %0d want 0", beat_cnt); end
    @(negedge clk);
    send(2);
    #1;
    tests++;
    if (beat_cnt !== 32'd2) begin fails++; $display("FAIL cnt_2: got %0d want 2", beat_cnt); end
    @(negedge clk);
  endtask
`endif
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
`ifdef AES_SHIFTROWS_BEATCNT_EN
    test_counter();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
